button_debouncer: RTL and testbench

//   Front-end conditioning stage for a raw mechanical push button, active-low.

---
 rtl/button_debouncer_pkg.sv | 16 +
 rtl/button_debouncer_sync_chain.sv | 25 ++
 rtl/button_debouncer.sv | 108 ++++++++++
 tb/tb_button_debouncer.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/button_debouncer_pkg.sv
// Shared types and defaults for the push-button debouncer.
// State encodings and the default qualification length.
package button_debouncer_pkg;

    typedef enum logic [1:0] {
        S_Released     = 2'd0,
        S_PressCheck   = 2'd1,
        S_Pressed      = 2'd2,
        S_ReleaseCheck = 2'd3
    } state_t;

    // 20 ms at 50 MHz
    localparam int DEBOUNCE_CYCLES_DEF = 1000000;
    localparam int SYNC_STAGES_DEF     = 2;

endpackage

// File: rtl/button_debouncer_sync_chain.sv
// Generic 1-bit multi-flop synchroniser with a parameterised reset value.
// Module name is sync_chain so it can be reused outside the debouncer.
module sync_chain #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic Clk,
    input  logic Reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            chain <= {STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Active-low push-button conditioner: synchroniser plus debounce FSM.
// ButtonOut only moves after DEBOUNCE_CYCLES+1 agreeing samples.
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
    input  logic Clk,
    input  logic Reset,
    input  logic ButtonIn,
    output logic ButtonOut,
    output logic Stable
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_out;
    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_n;
    logic             out_n;
    logic             stable_n;

    sync_chain #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_sync (
        .Clk   (Clk),
        .Reset (Reset),
        .d     (ButtonIn),
        .q     (sync_out)
    );

    always_comb begin
        state_n  = state;
        count_n  = count;
        out_n    = ButtonOut;
        stable_n = Stable;
        case (state)
            S_Released: begin
                if (!sync_out) begin
                    state_n  = S_PressCheck;
                    count_n  = '0;
                    stable_n = 1'b0;
                end
            end
            S_PressCheck: begin
                if (sync_out) begin
                    state_n  = S_Released;
                    count_n  = '0;
                    stable_n = 1'b1;
                end else if (count == CNT_LAST) begin
                    state_n  = S_Pressed;
                    count_n  = '0;
                    out_n    = 1'b0;
                    stable_n = 1'b1;
                end else begin
                    count_n = count + CNT_W'(1);
                end
            end
            S_Pressed: begin
                if (sync_out) begin
                    state_n  = S_ReleaseCheck;
                    count_n  = '0;
                    stable_n = 1'b0;
                end
            end
            S_ReleaseCheck: begin
                if (!sync_out) begin
                    state_n  = S_Pressed;
                    count_n  = '0;
                    stable_n = 1'b1;
                end else if (count == CNT_LAST) begin
                    state_n  = S_Released;
                    count_n  = '0;
                    out_n    = 1'b1;
                    stable_n = 1'b1;
                end else begin
                    count_n = count + CNT_W'(1);
                end
            end
            default: begin
                state_n  = S_Released;
                count_n  = '0;
                out_n    = 1'b1;
                stable_n = 1'b1;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= S_Released;
            count     <= '0;
            ButtonOut <= 1'b1;
            Stable    <= 1'b1;
        end else begin
            state     <= state_n;
            count     <= count_n;
            ButtonOut <= out_n;
            Stable    <= stable_n;
        end
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: directed scenarios plus random bursts,
// compared each cycle against a run-length reference model.
module tb_button_debouncer;

    localparam int D = 8;
    localparam int S = 2;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    logic ButtonIn = 1'b1;
    logic ButtonOut;
    logic Stable;

    int n_chk = 0;
    int n_fail = 0;

    logic pipe [S];
    logic m_out = 1'b1;
    int   run = 0;

    button_debouncer #(
        .DEBOUNCE_CYCLES (D),
        .SYNC_STAGES     (S)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .ButtonIn  (ButtonIn),
        .ButtonOut (ButtonOut),
        .Stable    (Stable)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: output flips once D+1 consecutive synchronised samples disagree with it
    task automatic model_edge(input logic rst, input logic btn);
        logic s;
        if (rst) begin
            for (int i = 0; i < S; i++) pipe[i] = 1'b1;
            m_out = 1'b1;
            run = 0;
        end else begin
            s = pipe[S-1];
            for (int i = S - 1; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0] = btn;
            if (s != m_out) begin
                run++;
                if (run == D + 1) begin
                    m_out = s;
                    run = 0;
                end
            end else begin
                run = 0;
            end
        end
    endtask

    task automatic step(input logic rst, input logic btn);
        Reset = rst;
        ButtonIn = btn;
        @(posedge Clk);
        model_edge(rst, btn);
        #1;
        chk("out", int'(ButtonOut), int'(m_out));
        chk("stable", int'(Stable), int'(run == 0));
    endtask

    task automatic hold(input logic btn, input int n);
        for (int i = 0; i < n; i++) step(1'b0, btn);
    endtask

    // Steps n edges at btn and returns the index of the edge where ButtonOut became want
    task automatic measure(input logic btn, input logic want, input int n, output int lat);
        lat = -1;
        for (int i = 0; i < n; i++) begin
            step(1'b0, btn);
            if (ButtonOut == want && lat < 0) lat = i;
        end
    endtask

    initial begin
        int lat;
        int lvl;
        int len;

        // Reset held with button pressed
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        chk("rst_out", int'(ButtonOut), 1);
        chk("rst_stable", int'(Stable), 1);
        hold(1'b1, 12);

        // Clean press
        measure(1'b0, 1'b0, 20, lat);
        chk("press_lat", lat, 10);

        // Clean release
        measure(1'b1, 1'b1, 20, lat);
        chk("release_lat", lat, 10);

        // 8-cycle glitch low: rejected
        hold(1'b0, 8);
        hold(1'b1, 14);
        chk("glitch8_out", int'(ButtonOut), 1);
        chk("glitch8_stable", int'(Stable), 1);

        // 9-cycle low: accepted at E10
        measure(1'b0, 1'b0, 9, lat);
        lat = -1;
        for (int i = 9; i < 14; i++) begin
            step(1'b0, 1'b1);
            if (!ButtonOut && lat < 0) lat = i;
        end
        chk("press9_lat", lat, 10);
        hold(1'b1, 14);

        // Bounce then held low
        for (int k = 0; k < 3; k++) begin
            hold(1'b0, 2);
            hold(1'b1, 2);
        end
        measure(1'b0, 1'b0, 20, lat);
        chk("bounce_lat", lat, 10);

        // 8-cycle high glitch while pressed
        hold(1'b1, 8);
        hold(1'b0, 14);
        chk("hglitch_out", int'(ButtonOut), 0);
        hold(1'b1, 14);

        // Reset mid-qualification, button held
        hold(1'b0, 7);
        step(1'b1, 1'b0);
        chk("midrst_out", int'(ButtonOut), 1);
        measure(1'b0, 1'b0, 20, lat);
        chk("midrst_lat", lat, 10);

        // Random bursts, occasional reset
        for (int seg = 0; seg < 60; seg++) begin
            lvl = int'($urandom_range(0, 1));
            len = int'($urandom_range(1, 14));
            if ($urandom_range(0, 19) == 0) step(1'b1, lvl[0]);
            hold(lvl[0], len);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
